// File: rtl/dsram_bridge_pkg.sv
// Shared definitions for the data-SRAM to 32-bit memory bridge:
// FSM state encoding, beat width and a lane-select helper.
package dsram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int BEAT_W = 32;

    function automatic logic half_active(input logic [3:0] sel_half);
        return |sel_half;
    endfunction

endpackage

// File: rtl/dsram_bridge.sv
// Splits one 64-bit core data access into up to two 32-bit memory beats
// (low word, then high word) and returns a one-cycle read response.
module dsram_bridge
    import dsram_bridge_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_sram_en,
    input  logic [7:0]        data_sram_we,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [63:0]       data_sram_wdata,
    input  logic [7:0]        data_ram_sel,
    output logic [63:0]       data_sram_rdata,
    output logic              data_sram_rvalid,
    output logic              stallreq,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [BEAT_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3'd7);
    localparam logic [ADDR_W-1:0] HI_OFS    = ADDR_W'(3'd4);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [7:0]        sel_q, sel_d;
    logic [7:0]        we_q, we_d;
    logic              wr_q, wr_d;
    logic              accept_s;

    assign accept_s = ((state_q == ST_IDLE) || (state_q == ST_RESP)) && data_sram_en;

    // State and latched request registers; reset abandons any beat in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            sel_q   <= 8'd0;
            we_q    <= 8'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            wr_q    <= wr_d;
        end
    end

    // Next-state logic: accept in IDLE/RESP, step through the selected halves.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        sel_d   = sel_q;
        we_d    = we_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    addr_d  = data_sram_addr & ADDR_MASK;
                    wdata_d = data_sram_wdata;
                    sel_d   = data_ram_sel;
                    we_d    = data_sram_we;
                    wr_d    = |data_sram_we;
                    rdata_d = 64'd0;
                    if (half_active(data_ram_sel[3:0])) begin
                        state_d = ST_LO;
                    end else if (half_active(data_ram_sel[7:4])) begin
                        state_d = ST_HI;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LO: begin
                if (mem_ready) begin
                    rdata_d[31:0] = mem_rdata;
                    state_d = half_active(sel_q[7:4]) ? ST_HI : ST_RESP;
                end else begin
                    state_d = ST_LO;
                end
            end
            ST_HI: begin
                if (mem_ready) begin
                    rdata_d[63:32] = mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_HI;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory beat outputs decode purely from registers, so they hold while waiting.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wstrb = 4'b0000;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = 32'd0;
        case (state_q)
            ST_LO: begin
                mem_req   = 1'b1;
                mem_we    = wr_q;
                mem_wstrb = wr_q ? we_q[3:0] : 4'b0000;
                mem_addr  = addr_q;
                mem_wdata = wdata_q[31:0];
            end
            ST_HI: begin
                mem_req   = 1'b1;
                mem_we    = wr_q;
                mem_wstrb = wr_q ? we_q[7:4] : 4'b0000;
                mem_addr  = addr_q + HI_OFS;
                mem_wdata = wdata_q[63:32];
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign stallreq         = (state_q == ST_LO) || (state_q == ST_HI) || accept_s;
    assign data_sram_rvalid = (state_q == ST_RESP) && !wr_q;
    assign data_sram_rdata  = rdata_q;

endmodule
